// File: rtl/katio_gate3_exerciser.sv
// Self-test sequencer for 3-input OR3/NOR3 gate cells: sweeps all {a,b,c} vectors and tallies mismatches.
// Optional first-failure capture (fail_vec/fail_valid) is built when KATIO_EXER_FAILVEC_EN is defined.
module katio_gate3_exerciser #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             or_in,
  input  logic             nor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef KATIO_EXER_FAILVEC_EN
  ,
  output logic [2:0]       fail_vec,
  output logic             fail_valid
`endif
);

  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t             state_q;
  logic [2:0]         vec_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [ERR_W-1:0]   err_q;
  logic               mismatch_d;
`ifdef KATIO_EXER_FAILVEC_EN
  logic [2:0]         fail_vec_q;
  logic               fail_valid_q;
`endif

  always_comb begin
    mismatch_d = (or_in != (|vec_q)) || (nor_in != ~(|vec_q));
  end

  // vec_q doubles as the registered gate drive; it is parked at 000 outside a sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
`ifdef KATIO_EXER_FAILVEC_EN
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            vec_q        <= '0;
            cnt_q        <= CNT_W'(SETTLE);
            err_q        <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
`ifdef KATIO_EXER_FAILVEC_EN
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
`endif
            state_q      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (mismatch_d) begin
            if (err_q != '1) begin
              err_q <= err_q + ERR_W'(1);
            end
`ifdef KATIO_EXER_FAILVEC_EN
            if (!fail_valid_q) begin
              fail_vec_q   <= vec_q;
              fail_valid_q <= 1'b1;
            end
`endif
          end
          if (vec_q == 3'd7) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            vec_q   <= vec_q + 3'd1;
            cnt_q   <= CNT_W'(SETTLE);
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: begin
          pass_q  <= (err_q == '0);
          busy_q  <= 1'b0;
          vec_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign {a, b, c} = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
`ifdef KATIO_EXER_FAILVEC_EN
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;
`endif

endmodule

// File: tb/tb_katio_gate3_exerciser.sv
// Bench for katio_gate3_exerciser: three differently parameterised instances against a timeline-based model.
module tb_katio_gate3_exerciser;

  localparam int N = 3;
  localparam int S_TAB [N] = '{1, 3, 2};
  localparam int E_TAB [N] = '{4, 4, 2};
  localparam int T_TAB [N] = '{16, 32, 24};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  int         fault;
  logic [7:0] mask;

  logic [N-1:0] av, bv, cv, orv, norv, busyv, donev, passv;
  logic [3:0]   err0, err1;
  logic [1:0]   err2;
`ifdef KATIO_EXER_FAILVEC_EN
  logic [2:0]   fv0, fv1, fv2;
  logic [N-1:0] fvalv;
`endif

  katio_gate3_exerciser #(.SETTLE(1), .ERR_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a(av[0]), .b(bv[0]), .c(cv[0]),
    .or_in(orv[0]), .nor_in(norv[0]), .busy(busyv[0]), .done(donev[0]),
    .pass(passv[0]), .err_cnt(err0)
`ifdef KATIO_EXER_FAILVEC_EN
    , .fail_vec(fv0), .fail_valid(fvalv[0])
`endif
  );

  katio_gate3_exerciser #(.SETTLE(3), .ERR_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(av[1]), .b(bv[1]), .c(cv[1]),
    .or_in(orv[1]), .nor_in(norv[1]), .busy(busyv[1]), .done(donev[1]),
    .pass(passv[1]), .err_cnt(err1)
`ifdef KATIO_EXER_FAILVEC_EN
    , .fail_vec(fv1), .fail_valid(fvalv[1])
`endif
  );

  katio_gate3_exerciser #(.SETTLE(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .a(av[2]), .b(bv[2]), .c(cv[2]),
    .or_in(orv[2]), .nor_in(norv[2]), .busy(busyv[2]), .done(donev[2]),
    .pass(passv[2]), .err_cnt(err2)
`ifdef KATIO_EXER_FAILVEC_EN
    , .fail_vec(fv2), .fail_valid(fvalv[2])
`endif
  );

  // Gate cells under test, with injectable faults
  logic [2:0] gv;
  always_comb begin
    orv  = '0;
    norv = '0;
    gv   = '0;
    for (int i = 0; i < N; i++) begin
      gv       = {av[i], bv[i], cv[i]};
      orv[i]   = |gv;
      norv[i]  = ~(|gv);
      case (fault)
        1: orv[i]  = 1'b0;
        2: norv[i] = |gv;
        3: orv[i]  = (|gv) ^ mask[gv];
        default: ;
      endcase
    end
  end

  function automatic bit vec_bad(int f, int v, logic [7:0] m);
    case (f)
      1: return v != 0;
      2: return 1'b1;
      3: return m[v];
      default: return 1'b0;
    endcase
  endfunction

  // Model: time since acceptance determines vector/busy/done; sample lands every SETTLE+1 edges
  bit       m_act  [N];
  int       m_t    [N];
  int       m_err  [N];
  bit       m_pass [N];
  bit [2:0] m_fv   [N];
  bit       m_fval [N];
  int       cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_act[i] <= 1'b0; m_t[i] <= 0; m_err[i] <= 0;
        m_pass[i] <= 1'b0; m_fv[i] <= '0; m_fval[i] <= 1'b0;
      end else if (!m_act[i]) begin
        if (start) begin
          m_act[i] <= 1'b1; m_t[i] <= 0; m_err[i] <= 0;
          m_pass[i] <= 1'b0; m_fv[i] <= '0; m_fval[i] <= 1'b0;
        end
      end else begin
        m_t[i] <= m_t[i] + 1;
        if (((m_t[i] + 1) % (S_TAB[i] + 1) == 0) && (m_t[i] + 1 <= 8 * (S_TAB[i] + 1))) begin
          if (vec_bad(fault, (m_t[i] + 1) / (S_TAB[i] + 1) - 1, mask)) begin
            if (m_err[i] < (1 << E_TAB[i]) - 1) m_err[i] <= m_err[i] + 1;
            if (!m_fval[i]) begin
              m_fv[i]   <= 3'((m_t[i] + 1) / (S_TAB[i] + 1) - 1);
              m_fval[i] <= 1'b1;
            end
          end
        end
        if (m_t[i] + 1 == 8 * (S_TAB[i] + 1) + 1) begin
          m_act[i]  <= 1'b0;
          m_pass[i] <= (m_err[i] == 0);
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int acc   [N];
  bit pbusy [N];

  function automatic int err_of(int i);
    case (i)
      0: return int'(err0);
      1: return int'(err1);
      default: return int'(err2);
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One cycle: wait for the falling edge and compare every instance against the model
  task automatic step();
    logic [2:0] e_abc;
    bit         e_busy, e_done;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      e_abc = '0; e_busy = 1'b0; e_done = 1'b0;
      if (m_act[i]) begin
        e_busy = 1'b1;
        if (m_t[i] < T_TAB[i]) e_abc = 3'(m_t[i] / (S_TAB[i] + 1));
        else begin
          e_abc  = 3'd7;
          e_done = 1'b1;
        end
      end
      total++;
      if ({av[i], bv[i], cv[i]} != e_abc || busyv[i] != e_busy || donev[i] != e_done ||
          passv[i] != m_pass[i] || err_of(i) != m_err[i]) begin
        bad++;
        $display("FAIL cycle%0d inst%0d: got abc=%b busy=%b done=%b pass=%b err=%0d, expected abc=%b busy=%b done=%b pass=%b err=%0d",
                 cyc, i, {av[i], bv[i], cv[i]}, busyv[i], donev[i], passv[i], err_of(i),
                 e_abc, e_busy, e_done, m_pass[i], m_err[i]);
      end
`ifdef KATIO_EXER_FAILVEC_EN
      begin
        logic [2:0] fva;
        fva = (i == 0) ? fv0 : (i == 1) ? fv1 : fv2;
        chk($sformatf("failvec_inst%0d", i), {fva, fvalv[i]}, {m_fv[i], m_fval[i]});
      end
`endif
      if (busyv[i] && !pbusy[i]) acc[i] = cyc;
      pbusy[i] = busyv[i];
      if (donev[i]) chk($sformatf("done_latency_inst%0d", i), cyc - acc[i], T_TAB[i]);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      step();
      if (busyv == '0) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic sweep();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; fault = 0; mask = '0;
    repeat (3) step();
    chk("rst_busy", int'(busyv), 0);
    chk("rst_abc", int'(av | bv | cv), 0);
    chk("rst_pass", int'(passv), 0);
    chk("rst_err0", int'(err0), 0);
    rst = 1'b0;
    step();

    fault = 0;
    sweep();
    chk("good_pass", int'(passv), 7);
    chk("good_err0", int'(err0), 0);

    fault = 1;
    sweep();
    chk("orstuck_err0", int'(err0), 7);
    chk("orstuck_err1", int'(err1), 7);
    chk("orstuck_err2_sat", int'(err2), 3);
    chk("orstuck_model_err", m_err[0], 7);
    chk("orstuck_pass", int'(passv), 0);
`ifdef KATIO_EXER_FAILVEC_EN
    chk("orstuck_failvec", int'(fv0), 1);
    chk("orstuck_failvalid", int'(fvalv[0]), 1);
`endif

    fault = 2;
    sweep();
    chk("norbad_err0", int'(err0), 8);
    chk("norbad_err2_sat", int'(err2), 3);
    chk("norbad_model_err", m_err[0], 8);
`ifdef KATIO_EXER_FAILVEC_EN
    chk("norbad_failvec", int'(fv0), 0);
`endif

    // Second start during the sweep must be ignored
    fault = 0;
    start = 1'b1; step(); start = 1'b0;
    repeat (9) step();
    start = 1'b1; step(); start = 1'b0;
    wait_idle();
    chk("restart_ignored_pass", int'(passv), 7);

    // Reset while dut0 drives vector 011
    start = 1'b1; step(); start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if ({av[0], bv[0], cv[0]} == 3'b011) found = 1'b1;
      else step();
    end
    chk("reach_vec3", int'(found), 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_busy", int'(busyv), 0);
    chk("midrst_abc", int'(av | bv | cv), 0);
    chk("midrst_err0", int'(err0), 0);
    sweep();
    chk("after_rst_pass", int'(passv), 7);
    chk("after_rst_err0", int'(err0), 0);

    rst = 1'b1; start = 1'b1; step();
    chk("rst_wins_busy", int'(busyv), 0);
    rst = 1'b0; start = 1'b0; step();
    chk("rst_wins_busy2", int'(busyv), 0);

    for (int r = 0; r < 12; r++) begin
      fault = $urandom_range(0, 3);
      mask  = 8'($urandom);
      start = 1'b1;
      repeat ($urandom_range(1, 40)) step();
      start = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 10)) step();
        rst = 1'b1; step(); rst = 1'b0;
      end
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
